// File: rtl/paint_stamp_sched.sv
// paint_stamp_sched: queues brush stamps from the SPI decode path and expands
// each one into row-major pixel writes on the shared frame memory port.
// The display reader always wins the port; stamp writes stall while it reads.
//
// state | meaning
// IDLE  | no stamp in progress, waiting for a queued command
// LOAD  | pop one command and compute its clamped pixel bounds
// STAMP | issuing one pixel write per non-stalled cycle
module paint_stamp_sched #(
  parameter int WIDTH  = 160,
  parameter int HEIGHT = 120,
  parameter int ADDR_W = 15,
  parameter int DEPTH  = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              brushUpdate,
  input  logic [7:0]        x,
  input  logic [7:0]        y,
  input  logic [2:0]        newColorUpdate,
  input  logic              updateConfig,
  input  logic              rdReq,
  input  logic [ADDR_W-1:0] rdAddr,
  output logic              rdGrant,
  output logic              memEn,
  output logic              memWe,
  output logic [ADDR_W-1:0] memAddr,
  output logic [2:0]        memWData,
  output logic              busy,
  output logic              overflow
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [8:0] W_LIM = 9'(WIDTH);
  localparam logic [8:0] H_LIM = 9'(HEIGHT);
  localparam logic signed [9:0] XMAX = 10'(WIDTH - 1);
  localparam logic signed [9:0] YMAX = 10'(HEIGHT - 1);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_STAMP} state_t;

  typedef struct packed {
    logic [7:0] x;
    logic [7:0] y;
    logic [2:0] col;
    logic [1:0] rad;
  } cmd_t;

  state_t r_state, w_next;
  cmd_t r_fifo [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr, r_rd_ptr;
  logic [PTR_W:0] r_count;
  logic [2:0] r_color, r_col;
  logic [1:0] r_radius;
  logic [7:0] r_cx, r_cy, r_x0, r_x1, r_y1;
  logic r_overflow;

  logic w_empty, w_full, w_push_try, w_push, w_pop, w_last, w_adv;
  cmd_t w_cmd, w_head;
  logic signed [9:0] w_hx, w_hy, w_hr, w_xlo, w_xhi, w_ylo, w_yhi;
  logic [7:0] w_x0, w_x1, w_y0, w_y1;
  logic [ADDR_W-1:0] w_wr_addr;

  assign w_empty    = (r_count == '0);
  assign w_full     = (r_count == (PTR_W+1)'(DEPTH));
  assign w_push_try = brushUpdate && ({1'b0, x} < W_LIM) && ({1'b0, y} < H_LIM);
  assign w_push     = w_push_try && !w_full;
  assign w_pop      = (r_state == S_LOAD);
  // A command always carries the config as registered before this cycle.
  assign w_cmd      = {x, y, r_color, r_radius};
  assign w_head     = r_fifo[r_rd_ptr];
  assign w_adv      = (r_state == S_STAMP) && !rdReq;
  assign w_last     = (r_cx == r_x1) && (r_cy == r_y1);
  assign w_wr_addr  = ADDR_W'(r_cy) * ADDR_W'(WIDTH) + ADDR_W'(r_cx);

  // Signed, widened bounds so x-r and x+r cannot wrap before clamping.
  always_comb begin
    w_hx  = $signed({2'b00, w_head.x});
    w_hy  = $signed({2'b00, w_head.y});
    w_hr  = $signed({8'd0, w_head.rad});
    w_xlo = w_hx - w_hr;
    w_xhi = w_hx + w_hr;
    w_ylo = w_hy - w_hr;
    w_yhi = w_hy + w_hr;
    w_x0  = (w_xlo < 10'sd0) ? 8'd0 : w_xlo[7:0];
    w_y0  = (w_ylo < 10'sd0) ? 8'd0 : w_ylo[7:0];
    w_x1  = (w_xhi > XMAX) ? XMAX[7:0] : w_xhi[7:0];
    w_y1  = (w_yhi > YMAX) ? YMAX[7:0] : w_yhi[7:0];
  end

  // Command FIFO storage; contents need no reset since pointers gate reads.
  always_ff @(posedge clk) begin
    if (w_push) r_fifo[r_wr_ptr] <= w_cmd;
  end

  // FIFO pointers, occupancy and the sticky drop flag.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      if (w_push && !w_pop)      r_count <= r_count + (PTR_W+1)'(1);
      else if (!w_push && w_pop) r_count <= r_count - (PTR_W+1)'(1);
      if (w_push_try && w_full) r_overflow <= 1'b1;
    end
  end

  // Brush color and radius latched from config updates.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_color  <= 3'd0;
      r_radius <= 2'd0;
    end else if (updateConfig) begin
      r_color  <= newColorUpdate;
      r_radius <= x[1:0];
    end
  end

  // Stamp cursor: load bounds on pop, advance row-major on each issued write.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_cx  <= 8'd0;
      r_cy  <= 8'd0;
      r_x0  <= 8'd0;
      r_x1  <= 8'd0;
      r_y1  <= 8'd0;
      r_col <= 3'd0;
    end else if (r_state == S_LOAD) begin
      r_cx  <= w_x0;
      r_cy  <= w_y0;
      r_x0  <= w_x0;
      r_x1  <= w_x1;
      r_y1  <= w_y1;
      r_col <= w_head.col;
    end else if (w_adv) begin
      if (r_cx == r_x1) begin
        r_cx <= r_x0;
        r_cy <= r_cy + 8'd1;
      end else begin
        r_cx <= r_cx + 8'd1;
      end
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  // Next-state logic; after the last pixel go straight to LOAD if more is queued.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (!w_empty) w_next = S_LOAD;
      S_LOAD:  w_next = S_STAMP;
      S_STAMP: if (w_adv && w_last) w_next = w_empty ? S_IDLE : S_LOAD;
      default: w_next = S_IDLE;
    endcase
  end

  // Memory port arbitration; the display read path is purely combinational.
  always_comb begin
    rdGrant  = 1'b0;
    memEn    = 1'b0;
    memWe    = 1'b0;
    memAddr  = '0;
    memWData = 3'd0;
    if (rdReq) begin
      rdGrant = 1'b1;
      memEn   = 1'b1;
      memAddr = rdAddr;
    end else if (r_state == S_STAMP) begin
      memEn    = 1'b1;
      memWe    = 1'b1;
      memAddr  = w_wr_addr;
      memWData = r_col;
    end
  end

  assign busy     = !w_empty || (r_state != S_IDLE);
  assign overflow = r_overflow;

endmodule
